// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared constants, request FSM states and sample type for frame_sample_buffer.
package frame_buf_pkg;

    localparam int FB_WIDTH = 16;
    localparam int FB_DEPTH = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef logic signed [FB_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with wrapping pointers and a separate 0..DEPTH occupancy counter.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic signed [WIDTH-1:0]   i_data,
    output logic signed [WIDTH-1:0]   o_head,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic signed [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr;
    logic [AW-1:0]           r_rd;
    logic [CW-1:0]           r_count;

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

endmodule

// File: rtl/frame_sample_buffer.sv
// frame_sample_buffer: pulls samples from dynamics on request and releases one per codec frame.
// Optional FRAME_VOLUME_EN adds a volume port applying an arithmetic right shift on pop.
module frame_sample_buffer
    import frame_buf_pkg::*;
#(
    parameter int WIDTH = FB_WIDTH,
    parameter int DEPTH = FB_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_frame,
    input  logic signed [WIDTH-1:0]   sample_in,
    input  logic                      new_sample_ready,
`ifdef FRAME_VOLUME_EN
    input  logic [2:0]                volume,
`endif
    output logic                      generate_next_sample,
    output logic signed [WIDTH-1:0]   sample_out,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      underflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_req_nxt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic [CW-1:0]           w_fill_nxt;
    logic signed [WIDTH-1:0] w_head;
    logic signed [WIDTH-1:0] w_pop_val;

    assign w_empty    = fill_level == '0;
    assign w_pop      = new_frame && !w_empty;
    assign w_push     = r_state == WAIT && new_sample_ready;
    assign w_fill_nxt = fill_level + CW'(w_push) - CW'(w_pop);

`ifdef FRAME_VOLUME_EN
    assign w_pop_val = w_head >>> volume;
`else
    assign w_pop_val = w_head;
`endif

    // Look at post-edge occupancy so a request can issue on the same edge as a push or pop
    always_comb begin
        w_req_nxt   = (r_state == IDLE || w_push) && (w_fill_nxt < CW'(DEPTH));
        w_state_nxt = (w_req_nxt || (r_state == WAIT && !w_push)) ? WAIT : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state              <= IDLE;
            generate_next_sample <= 1'b0;
            sample_out           <= '0;
            underflow            <= 1'b0;
        end else begin
            r_state              <= w_state_nxt;
            generate_next_sample <= w_req_nxt;
            if (w_pop) sample_out <= w_pop_val;
            if (new_frame && w_empty) underflow <= 1'b1;
        end
    end

    sample_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .i_rst_n(reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (sample_in),
        .o_head (w_head),
        .o_count(fill_level)
    );

endmodule

// File: tb/tb_frame_sample_buffer.sv
// tb_frame_sample_buffer: directed and random stimulus against a queue-based reference model.
module tb_frame_sample_buffer;
    import frame_buf_pkg::*;

`ifdef FRAME_VOLUME_EN
    localparam bit VOL_EN = 1'b1;
`else
    localparam bit VOL_EN = 1'b0;
`endif
    localparam int DEPTH = FB_DEPTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   nf = 1'b0;
    logic                   rdy = 1'b0;
    sample_t                sin = '0;
    logic [2:0]             vol = '0;
    logic                   gen;
    logic                   uf;
    sample_t                sout;
    logic [$clog2(DEPTH):0] fill;

    sample_t q[$];
    bit      pending;
    bit      exp_gen;
    bit      exp_uf;
    sample_t exp_out;
    int      n_cmp = 0;
    int      n_err = 0;
    string   phase = "reset";
    sample_t vals[4] = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    sample_t a, b, c;

    always #5 clk = ~clk;

    frame_sample_buffer #(
        .WIDTH(FB_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .new_frame           (nf),
        .sample_in           (sin),
        .new_sample_ready    (rdy),
`ifdef FRAME_VOLUME_EN
        .volume              (vol),
`endif
        .generate_next_sample(gen),
        .sample_out          (sout),
        .fill_level          (fill),
        .underflow           (uf)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s/%s: got %0d, expected %0d at %0t", phase, tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pending = 1'b0;
        exp_gen = 1'b0;
        exp_uf  = 1'b0;
        exp_out = '0;
    endtask

    task automatic chk_all();
        chk("gen", gen, exp_gen);
        chk("fill", fill, q.size());
        chk("out", sout, exp_out);
        chk("uflow", uf, exp_uf);
    endtask

    // One clock: the model applies pop-before-push, then issues a request whenever
    // none is outstanding and a slot remains after this edge.
    task automatic tick();
        bit      push;
        sample_t h;
        push = pending && rdy;
        @(posedge clk);
        if (nf) begin
            if (q.size() > 0) begin
                h = q.pop_front();
                exp_out = h >>> (VOL_EN ? vol : 3'd0);
            end else begin
                exp_uf = 1'b1;
            end
        end
        if (push) begin
            q.push_back(sin);
            pending = 1'b0;
        end
        exp_gen = !pending && q.size() < DEPTH;
        if (exp_gen) pending = 1'b1;
        #1;
        chk_all();
    endtask

    task automatic serve(input sample_t v, input int lat);
        repeat (lat - 1) tick();
        rdy = 1'b1;
        sin = v;
        tick();
        rdy = 1'b0;
    endtask

    task automatic pop_one();
        nf = 1'b1;
        tick();
        nf = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (4) begin
            nf  = 1'($urandom);
            rdy = 1'($urandom);
            sin = sample_t'($urandom);
            vol = 3'($urandom);
            @(posedge clk);
            #1;
            chk_all();
        end
        nf = 1'b0;
        rdy = 1'b0;
        vol = '0;
        rst_n = 1'b1;
        tick();
        chk("first_req", gen, 1);
        tick();

        phase = "fill";
        for (int i = 0; i < 4; i++) begin
            serve(vals[i], 3);
            chk("fill_step", fill, i + 1);
        end
        repeat (3) tick();
        chk("no_req_full", gen, 0);

        phase = "unsolicited";
        rdy = 1'b1;
        sin = sample_t'($urandom);
        tick();
        rdy = 1'b0;
        chk("unsol_fill", fill, 4);

        phase = "drain";
        for (int i = 0; i < 4; i++) begin
            pop_one();
            chk("drain_val", sout, vals[i]);
            if (i == 0) chk("req_on_pop", gen, 1);
            tick();
        end

        phase = "underflow";
        pop_one();
        chk("uf_set", uf, 1);
        chk("uf_hold", sout, 400);
        repeat (3) tick();
        chk("uf_sticky", uf, 1);
        serve(-16'sd10400, 2);
        pop_one();
        chk("neg_exact", sout, -10400);
        chk("uf_still", uf, 1);

        phase = "simultaneous";
        a = sample_t'($urandom);
        b = sample_t'($urandom);
        c = sample_t'($urandom);
        serve(a, 1);
        serve(b, 2);
        chk("pre_fill", fill, 2);
        nf  = 1'b1;
        rdy = 1'b1;
        sin = c;
        tick();
        nf  = 1'b0;
        rdy = 1'b0;
        chk("simul_fill", fill, 2);
        chk("simul_head", sout, a);
        pop_one();
        chk("order_b", sout, b);
        pop_one();
        chk("order_c", sout, c);

        if (VOL_EN) begin
            phase = "volume";
            vol = 3'd3;
            serve(16'sd10400, 2);
            serve(-16'sd10400, 2);
            pop_one();
            chk("vol_pos", sout, 1300);
            pop_one();
            chk("vol_neg", sout, -1300);
            vol = '0;
        end

        phase = "reset_in_wait";
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(posedge clk);
        #1;
        rdy = 1'b1;
        sin = sample_t'($urandom);
        rst_n = 1'b1;
        tick();
        rdy = 1'b0;
        chk("post_rst_fill", fill, 0);
        chk("post_rst_req", gen, 1);

        phase = "random";
        repeat (400) begin
            nf  = ($urandom_range(3) == 0);
            rdy = pending ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            sin = sample_t'($urandom);
            vol = 3'($urandom);
            tick();
        end
        nf  = 1'b0;
        rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_sample_buffer.md
# frame_sample_buffer

Sample-rate decoupling stage directly downstream of `dynamics`. Pulls attenuated samples (`final_sample`) from the note/dynamics pipeline with a request/ready handshake and holds them in a small FIFO. It releases exactly one sample to the codec per `new_frame` strobe. It absorbs variable upstream latency and reports underflow when the pipeline cannot keep up.

## Interface
Parameters:
- `WIDTH`, 16: sample width, two's-complement signed.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `new_frame`  in  1  codec frame strobe, one-cycle pulse.
- `sample_in`  in  WIDTH  sample from `dynamics` (`final_sample`).
- `new_sample_ready`  in  1  upstream strobe: `sample_in` valid this cycle.
- `generate_next_sample`  out  1  one-cycle request to upstream for the next sample.
- `sample_out`  out  WIDTH  sample presented to the codec; held between frames.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `underflow`  out  1  sticky; set when a frame arrives with the FIFO empty.
- `volume`  in  3  output attenuation shift; present only with `FRAME_VOLUME_EN`.

## Operation
- The request FSM has two states.
  - IDLE: if `fill_level < DEPTH`, register `generate_next_sample`=1 for exactly one cycle and go to WAIT.
  - WAIT: on `new_sample_ready`=1, push `sample_in` and return to IDLE.
- At most one request is outstanding. The outstanding request reserves a slot, so a push never overflows.
- `new_sample_ready` in IDLE (unsolicited) is ignored. No push occurs and no state changes.
- On `new_frame`=1:
  - FIFO non-empty: pop the head into the `sample_out` register.
  - FIFO empty: `sample_out` holds its previous value and `underflow` sets.
- `new_frame` held high for N cycles pops N times. Upstream must pulse it.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved. The pop takes the old head; if the FIFO was empty, the pop underflows and the push still lands.
- Read and write pointers wrap modulo `DEPTH`. `fill_level` is a separate counter in the range 0..DEPTH.
- Samples pass through bit-exact when `FRAME_VOLUME_EN` is not defined. Sign is preserved.
- `underflow` clears only on reset.

## Timing
- Reset values: `sample_out`=0, `fill_level`=0, `underflow`=0, `generate_next_sample`=0, FSM=IDLE, pointers=0.
- The first `generate_next_sample` pulse occurs on the first rising edge after `reset` deasserts.
- A push is visible in `fill_level` on the edge after `new_sample_ready`. The next request pulse can assert on that same edge.
- Pop latency: `sample_out` updates on the rising edge that samples `new_frame`=1.
- Minimum request-to-ready spacing is one cycle; there is no maximum. WAIT persists indefinitely.
- Reset asserted mid-transfer: everything is cleared immediately. Any outstanding request is abandoned. A `new_sample_ready` that arrives after reset release is treated as unsolicited.

## Configuration
- `FRAME_VOLUME_EN` defined:
  - The `volume` port exists.
  - On pop, `sample_out` = head >>> `volume`, using an arithmetic shift from 0 to 7 places.
  - `volume` is sampled on the pop edge.
- `FRAME_VOLUME_EN` not defined: the `volume` port and the shifter are absent, and the pop is a direct copy.

## Structure
- Shared package `frame_buf_pkg`: default `WIDTH`/`DEPTH` constants, the FSM state enum (IDLE, WAIT), and the sample typedef (signed [WIDTH-1:0]).
- One sub-module, `sample_fifo`: a synchronous FIFO with push, pop, head, count, and pointer wrap.
- The top level holds the request FSM, the output register, the underflow flag, and the optional shifter.

## Test plan
- Reset: hold `reset`=0 with random inputs. All outputs must read 0. Release it; `generate_next_sample` must pulse exactly one cycle on the first edge.
- Fill: answer each request 3 cycles later with 100, 200, 300, 400. `fill_level` must step 1→4, and no request may be issued while full.
- Drain: four `new_frame` pulses must give `sample_out` = 100, 200, 300, 400 in order. A new request must pulse on the edge of the first pop.
- Underflow and sign: starting empty with no upstream response, `new_frame` → `sample_out` holds, `underflow`=1 and remains sticky. Then push −10400; the pop must yield −10400 exactly.
- Simultaneous events:
  - At `fill_level`=2, drive `new_frame` and `new_sample_ready` in the same cycle → `fill_level` stays 2 and order is preserved.
  - Send an unsolicited `new_sample_ready` → ignored.
  - Assert reset while in WAIT → all state is cleared.
- Volume (`FRAME_VOLUME_EN`): push 10400 and −10400 with `volume`=3. The pops must yield 1300 and −1300.
